// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU bus arbiter: copies DMA_LEN bytes from {src,idx} to OAM_BASE+idx,
// one byte per M-cycle, while fencing the CPU off the main bus but leaving HRAM reachable.
module oam_dma_arbiter #(
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] DMA_REG  = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic        hram_rd,
  output logic        hram_wr,
  output logic [7:0]  hram_wdata,
  input  logic [7:0]  hram_rdata,
  output logic        dma_active,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic [7:0] byte_q, byte_d;

  logic       boundary;
  logic       hram_sel;
  logic       reg_sel;
  logic       main_sel;
  logic       reg_wr;
  logic       last_idx;
  logic [7:0] src_eff;

  assign boundary = (t_cycle == 2'b11);
  assign hram_sel = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign reg_sel  = (cpu_addr == DMA_REG);
  assign main_sel = !hram_sel && !reg_sel;
  assign reg_wr   = boundary && cpu_wr && reg_sel;
  assign last_idx = (idx_q == 8'(DMA_LEN - 1));
  // Sources in echo RAM fold back onto work RAM.
  assign src_eff  = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  assign dma_active = (state_q != IDLE);
  assign dbg_state  = state_q;

  assign hram_addr  = cpu_addr[6:0];
  assign hram_rd    = cpu_rd && hram_sel;
  assign hram_wr    = cpu_wr && hram_sel;
  assign hram_wdata = cpu_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
      src_q   <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    byte_d  = byte_q;
    if (reg_wr) src_d = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (reg_wr) begin
          state_d = START;
          idx_d   = 8'h00;
        end
      end
      START: begin
        if (reg_wr) idx_d = 8'h00;
        else if (boundary) state_d = XFER;
      end
      XFER: begin
        if (t_cycle == 2'b01) byte_d = mem_rdata;
        // A register write restarts the copy from the new source.
        if (reg_wr) begin
          state_d = START;
          idx_d   = 8'h00;
        end else if (boundary) begin
          if (last_idx) begin
            state_d = IDLE;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'h01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_rd    = cpu_rd && main_sel;
    mem_wr    = cpu_wr && main_sel;
    mem_wdata = cpu_wdata;
    if (dma_active) begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = byte_q;
      mem_addr  = OAM_BASE + {8'h00, idx_q};
      if (state_q == XFER) begin
        // First half of the M-cycle reads the source, second half writes OAM.
        if (!t_cycle[1]) begin
          mem_rd   = 1'b1;
          mem_addr = {src_eff, idx_q};
        end else begin
          mem_wr   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (hram_sel)        cpu_rdata = hram_rdata;
    else if (reg_sel)    cpu_rdata = src_q;
    else if (dma_active) cpu_rdata = 8'hFF;
    else                 cpu_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: bus/HRAM memory models, a vector table for CPU decode and
// fencing, and a DMA scoreboard fed when a transfer is started and drained by a bus monitor.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic        hram_rd;
  logic        hram_wr;
  logic [7:0]  hram_wdata;
  logic [7:0]  hram_rdata;
  logic        dma_active;
  logic [1:0]  dbg_state;

  localparam int DMA_LEN = 160;
  localparam int NV      = 16;

  typedef struct {
    logic        dma;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [11:0] exp;   // {cpu_rdata, mem_rd, mem_wr, hram_rd, hram_wr}
  } vec_t;

  vec_t        tbl[NV];
  logic [11:0] vec_q[$];
  logic [39:0] dma_q[$];  // {read addr, write addr, data}
  logic [7:0]  mem[65536];
  logic [7:0]  hram[128];
  int          errors = 0;
  int          checks = 0;
  int          mon_pops = 0;
  int          spurious = 0;
  logic        watch_no_wr = 1'b0;
  logic [15:0] rd_seen = 16'h0000;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .hram_addr(hram_addr), .hram_rd(hram_rd), .hram_wr(hram_wr), .hram_wdata(hram_wdata),
    .hram_rdata(hram_rdata),
    .dma_active(dma_active), .dbg_state(dbg_state)
  );

  // ---------------- clock / t-cycle ----------------
  always #5 clk = ~clk;

  initial begin
    t_cycle = 2'b00;
    forever begin
      @(posedge clk);
      #1 t_cycle = t_cycle + 2'd1;
    end
  end

  // ---------------- memory models ----------------
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_rdata  = mem[mem_addr];
  assign hram_rdata = hram[hram_addr];

  always @(posedge clk) begin
    if (mem_wr)  mem[mem_addr]   = mem_wdata;
    if (hram_wr) hram[hram_addr] = hram_wdata;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: every OAM write closing an M-cycle is matched against the scoreboard.
  always @(negedge clk) begin
    if (dma_active && t_cycle == 2'd1 && mem_rd) rd_seen = mem_addr;
    if (watch_no_wr && mem_wr) spurious++;
    if (t_cycle == 2'd3 && mem_wr) begin
      if (dma_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dma_unexpected_wr: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        check("dma_xfer", {24'h0, rd_seen, mem_addr, mem_wdata}, {24'h0, dma_q.pop_front()});
        mon_pops++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align_t0();
    do begin
      @(posedge clk);
      #2;
    end while (t_cycle != 2'b00);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    align_t0();
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    repeat (4) @(posedge clk);
    #2 cpu_wr = 1'b0;
  endtask

  task automatic push_xfer(input logic [7:0] src);
    logic [7:0]  eff;
    logic [15:0] ra;
    eff = (src >= 8'hE0) ? src - 8'h20 : src;
    for (int i = 0; i < DMA_LEN; i++) begin
      ra = {eff, i[7:0]};
      dma_q.push_back({ra, 16'hFE00 + i[15:0], pat(ra)});
    end
  endtask

  task automatic check_oam(input string name, input logic [7:0] src);
    int          bad;
    logic [7:0]  eff;
    logic [15:0] oa;
    bad = 0;
    eff = (src >= 8'hE0) ? src - 8'h20 : src;
    for (int i = 0; i < DMA_LEN; i++) begin
      oa = 16'hFE00 + i[15:0];
      if (mem[oa] !== pat({eff, i[7:0]})) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic apply_vec(input vec_t v);
    align_t0();
    cpu_addr  = v.addr;
    cpu_rd    = v.rd;
    cpu_wr    = v.wr;
    cpu_wdata = v.wdata;
    vec_q.push_back(v.exp);
    @(negedge clk);
    check($sformatf("vec_%04h", v.addr), {cpu_rdata, mem_rd, mem_wr, hram_rd, hram_wr},
          vec_q.pop_front());
    @(posedge clk);
    #2;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic run_vectors(input logic phase);
    for (int i = 0; i < NV; i++)
      if (tbl[i].dma == phase) apply_vec(tbl[i]);
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (mon_pops < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_pops_reached", mon_pops >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dma_active && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", dma_active, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int base;
    for (int i = 0; i < 65536; i++) mem[i] = pat(i[15:0]);
    for (int i = 0; i < 128; i++) hram[i] = i[7:0] ^ 8'hA5;

    tbl[0]  = '{1'b0, 16'h8000, 1'b1, 1'b0, 8'h00, {8'hDA, 4'b1000}};
    tbl[1]  = '{1'b0, 16'hFF90, 1'b1, 1'b0, 8'h00, {8'hB5, 4'b0010}};
    tbl[2]  = '{1'b0, 16'hFF46, 1'b1, 1'b0, 8'h00, {8'h00, 4'b0000}};
    tbl[3]  = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 8'h00, {8'h5A, 4'b1000}};
    tbl[4]  = '{1'b0, 16'hFF80, 1'b1, 1'b0, 8'h00, {8'hA5, 4'b0010}};
    tbl[5]  = '{1'b0, 16'hFF7F, 1'b1, 1'b0, 8'h00, {8'hDA, 4'b1000}};
    tbl[6]  = '{1'b0, 16'hC000, 1'b0, 1'b1, 8'h33, {8'h9A, 4'b0100}};
    tbl[7]  = '{1'b0, 16'hFF85, 1'b0, 1'b1, 8'h77, {8'hA0, 4'b0001}};
    tbl[8]  = '{1'b0, 16'hFFFE, 1'b0, 1'b1, 8'h11, {8'hDB, 4'b0001}};
    tbl[9]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 8'h00, {8'hFF, 4'b1000}};
    tbl[10] = '{1'b1, 16'hC000, 1'b0, 1'b1, 8'hAB, {8'hFF, 4'b1000}};
    tbl[11] = '{1'b1, 16'hFF90, 1'b1, 1'b0, 8'h00, {8'hB5, 4'b1010}};
    tbl[12] = '{1'b1, 16'hFF90, 1'b0, 1'b1, 8'h5C, {8'hB5, 4'b1001}};
    tbl[13] = '{1'b1, 16'hFF90, 1'b1, 1'b0, 8'h00, {8'h5C, 4'b1010}};
    tbl[14] = '{1'b1, 16'hFF46, 1'b1, 1'b0, 8'h00, {8'hE2, 4'b1000}};
    tbl[15] = '{1'b1, 16'hFF85, 1'b1, 1'b0, 8'h00, {8'h77, 4'b1010}};

    rst = 1'b0; cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_dma_active", dma_active, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    check("reset_mem_wr", mem_wr, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;

    run_vectors(1'b0);

    // Plain transfer from C1: active window length and OAM contents.
    cpu_write(16'hFF46, 8'hC1);
    push_xfer(8'hC1);
    cnt = 0;
    @(negedge clk);
    while (dma_active && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check("active_clks", cnt, 644);
    check("q_empty_c1", dma_q.size(), 0);
    check_oam("oam_c1", 8'hC1);

    // Echo-RAM source, with CPU traffic during the copy.
    base = mon_pops;
    cpu_write(16'hFF46, 8'hE2);
    push_xfer(8'hE2);
    wait_pops(base + 3);
    run_vectors(1'b1);
    wait_idle();
    check("q_empty_e2", dma_q.size(), 0);
    check_oam("oam_e2", 8'hE2);

    // Restart at index 50 with a new source.
    base = mon_pops;
    cpu_write(16'hFF46, 8'hC1);
    push_xfer(8'hC1);
    wait_pops(base + 50);
    cpu_write(16'hFF46, 8'hC3);
    check("restart_active", dma_active, 1'b1);
    check("restart_state", dbg_state, 2'd1);
    dma_q.delete();
    push_xfer(8'hC3);
    wait_idle();
    check("q_empty_c3", dma_q.size(), 0);
    check_oam("oam_c3", 8'hC3);

    // Reset in the middle of index 80.
    base = mon_pops;
    cpu_write(16'hFF46, 8'hC1);
    push_xfer(8'hC1);
    wait_pops(base + 80);
    @(posedge clk);
    #3;
    @(posedge clk);
    #3;
    rst = 1'b0;
    watch_no_wr = 1'b1;
    #1;
    check("abort_dma_active", dma_active, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    dma_q.delete();
    @(negedge clk);
    check("abort_dma_active_next", dma_active, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    apply_vec(tbl[2]);
    repeat (400) @(posedge clk);
    check("no_dma_wr_after_reset", spurious, 0);
    watch_no_wr = 1'b0;

    check("final_q_empty", dma_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
